i2c_tx_cfg_bank: RTL and testbench

//  Multi-channel, clocked TX configuration register bank feeding the I2C TX engines.

---
 rtl/i2c_tx_cfg_bank.sv | 195 +++++++++++++++++++
 tb/tb_i2c_tx_cfg_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_tx_cfg_bank.sv
// i2c_tx_cfg_bank
//   Per-channel TX configuration registers for the I2C TX engines. Each channel
//   takes a legal burst length, then a legal transfer size. It then reports
//   cfg_ready and keeps its configuration frozen while its engine runs.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, rd_en       host write / read strobes (shared addr, wdata)
//   addr               {channel, offset}: 0 BURST, 1 SIZE, 2 STATUS (RO), 3 reserved
//   wdata / rdata      host write data / registered read data (1-cycle latency)
//   wr_err             one-cycle pulse after a rejected write
//   tx_start, tx_done  per-channel engine handshakes
//   cfg_ready          per-channel configuration complete and idle
//   cfg_burst          packed 7-bit bursts, channel c at [7c+6:7c]
//   cfg_size           packed 3-bit sizes, channel c at [3c+2:3c]
module i2c_tx_cfg_bank #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BLOG2 = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                wr_err,
  input  logic [NUM_CH-1:0]   tx_start,
  input  logic [NUM_CH-1:0]   tx_done,
  output logic [NUM_CH-1:0]   cfg_ready,
  output logic [NUM_CH*7-1:0] cfg_burst,
  output logic [NUM_CH*3-1:0] cfg_size
);

  localparam int CH_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_BURST_OK = 2'd1,
    ST_READY    = 2'd2,
    ST_LOCKED   = 2'd3
  } state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [6:0]        burst_q [NUM_CH];
  logic [6:0]        burst_d [NUM_CH];
  logic [2:0]        size_q  [NUM_CH];
  logic [2:0]        size_d  [NUM_CH];
  logic [NUM_CH-1:0] cfg_ready_q, cfg_ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_err_q, wr_err_d;

  logic [CH_W-1:0]   ch_s;
  logic [1:0]        off_s;
  logic              burst_legal_s;
  logic              size_legal_s;
  logic              wr_accept_s;
  logic [DATA_W-1:0] rd_val_s;

  assign ch_s  = addr[ADDR_W-1:2];
  assign off_s = addr[1:0];

  // Value legality, compared over the full write-data width.
  always_comb begin
    burst_legal_s = 1'b0;
    for (int k = 0; k <= MAX_BLOG2; k++) begin
      burst_legal_s = burst_legal_s | (wdata == (DATA_W'(1) << k));
    end
    size_legal_s = (wdata == DATA_W'(1)) || (wdata == DATA_W'(2)) ||
                   (wdata == DATA_W'(4));
  end

  // Per-channel FSM and register next-state; any write no channel accepts is an error.
  always_comb begin
    wr_accept_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic hit_b, hit_s;
      hit_b = wr_en && (ch_s == CH_W'(c)) && (off_s == 2'd0) && burst_legal_s;
      hit_s = wr_en && (ch_s == CH_W'(c)) && (off_s == 2'd1) && size_legal_s;
      state_d[c] = state_q[c];
      burst_d[c] = burst_q[c];
      size_d[c]  = size_q[c];
      case (state_q[c])
        ST_EMPTY: begin
          if (hit_b) begin
            burst_d[c]  = wdata[6:0];
            state_d[c]  = ST_BURST_OK;
            wr_accept_s = 1'b1;
          end else begin
            state_d[c] = ST_EMPTY;
          end
        end
        ST_BURST_OK: begin
          if (hit_b) begin
            burst_d[c]  = wdata[6:0];
            wr_accept_s = 1'b1;
          end else if (hit_s) begin
            size_d[c]   = wdata[2:0];
            state_d[c]  = ST_READY;
            wr_accept_s = 1'b1;
          end else begin
            state_d[c] = ST_BURST_OK;
          end
        end
        ST_READY: begin
          // tx_start has priority; a coincident write to this channel is rejected.
          if (tx_start[c]) begin
            state_d[c] = ST_LOCKED;
          end else if (hit_b) begin
            burst_d[c]  = wdata[6:0];
            state_d[c]  = ST_BURST_OK;
            wr_accept_s = 1'b1;
          end else if (hit_s) begin
            size_d[c]   = wdata[2:0];
            wr_accept_s = 1'b1;
          end else begin
            state_d[c] = ST_READY;
          end
        end
        ST_LOCKED: begin
          if (tx_done[c]) begin
            state_d[c] = ST_EMPTY;
          end else begin
            state_d[c] = ST_LOCKED;
          end
        end
        default: state_d[c] = ST_EMPTY;
      endcase
      cfg_ready_d[c] = (state_q[c] == ST_READY);
    end
    wr_err_d = wr_en && !wr_accept_s;
  end

  // Read mux over pre-write register values; unmatched channel or offset reads 0.
  always_comb begin
    rd_val_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_s == CH_W'(c)) begin
        case (off_s)
          2'd0:    rd_val_s = DATA_W'(burst_q[c]);
          2'd1:    rd_val_s = DATA_W'(size_q[c]);
          2'd2:    rd_val_s = DATA_W'({cfg_ready_q[c], state_q[c]});
          default: rd_val_s = '0;
        endcase
      end else begin
        rd_val_s = rd_val_s;
      end
    end
    if (rd_en) begin
      rdata_d = rd_val_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, configuration and host-response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_EMPTY;
        burst_q[c] <= 7'd0;
        size_q[c]  <= 3'd0;
      end
      cfg_ready_q <= '0;
      rdata_q     <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        burst_q[c] <= burst_d[c];
        size_q[c]  <= size_d[c];
      end
      cfg_ready_q <= cfg_ready_d;
      rdata_q     <= rdata_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Pack per-channel configuration registers onto the output buses.
  always_comb begin
    cfg_burst = '0;
    cfg_size  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_burst[7*c +: 7] = burst_q[c];
      cfg_size[3*c +: 3]  = size_q[c];
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign rdata     = rdata_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_i2c_tx_cfg_bank.sv
module tb_i2c_tx_cfg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        wr_err;
  logic [1:0]  tx_start = 2'b00;
  logic [1:0]  tx_done = 2'b00;
  logic [1:0]  cfg_ready;
  logic [13:0] cfg_burst;
  logic [5:0]  cfg_size;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd_q [$];
  logic        err_q [$];
  logic        mon_rd, mon_wr;

  i2c_tx_cfg_bank #(.NUM_CH(2), .ADDR_W(4), .DATA_W(32), .MAX_BLOG2(6)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .wr_err(wr_err), .tx_start(tx_start),
    .tx_done(tx_done), .cfg_ready(cfg_ready), .cfg_burst(cfg_burst),
    .cfg_size(cfg_size)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read data / write status for each cycle the DUT responds.
  always @(posedge clk) begin
    mon_rd = rd_en && rst_n;
    mon_wr = wr_en && rst_n;
    #1;
    if (mon_rd) begin
      if (rd_q.size() == 0) begin
        check("rd_queue_underflow", 32'd1, 32'd0);
      end else begin
        check("rdata", rdata, rd_q.pop_front());
      end
    end
    if (mon_wr) begin
      if (err_q.size() == 0) begin
        check("err_queue_underflow", 32'd1, 32'd0);
      end else begin
        check("wr_err", {31'd0, wr_err}, {31'd0, err_q.pop_front()});
      end
    end else begin
      check("wr_err_idle", {31'd0, wr_err}, 32'd0);
    end
  end

  // One bus cycle: drive at negedge, push expectations, release at next negedge.
  task automatic step(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d,
                      input logic [1:0] ts, input logic [1:0] td,
                      input bit e_err, input logic [31:0] e_rd);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d; tx_start = ts; tx_done = td;
    if (w) err_q.push_back(e_err);
    if (r) rd_q.push_back(e_rd);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; tx_start = 2'b00; tx_done = 2'b00;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input bit e_err);
    step(1'b1, 1'b0, a, d, 2'b00, 2'b00, e_err, 32'd0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    step(1'b0, 1'b1, a, 32'd0, 2'b00, 2'b00, 1'b0, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_ready", {30'd0, cfg_ready}, 32'd0);
    check("rst_burst", {18'd0, cfg_burst}, 32'd0);
    check("rst_size", {26'd0, cfg_size}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // ch0: BURST=16, SIZE=4, ready two cycles after the SIZE write
    wr(4'd0, 32'd16, 1'b0);
    wr(4'd1, 32'd4, 1'b0);
    check("ready_lag", {30'd0, cfg_ready}, 32'd0);
    idle(1);
    check("ch0_ready", {30'd0, cfg_ready}, 32'd1);
    check("ch0_burst", {25'd0, cfg_burst[6:0]}, 32'd16);
    check("ch0_size", {29'd0, cfg_size[2:0]}, 32'd4);
    rd(4'd2, 32'd6);

    // ch1: illegal values and SIZE before BURST
    wr(4'd4, 32'd12, 1'b1);
    wr(4'd5, 32'd3, 1'b1);
    wr(4'd5, 32'd2, 1'b1);
    rd(4'd6, 32'd0);
    check("ch1_not_ready", {31'd0, cfg_ready[1]}, 32'd0);
    wr(4'd4, 32'd128, 1'b1);
    wr(4'd4, 32'd0, 1'b1);
    wr(4'd4, 32'h0001_0010, 1'b1);
    wr(4'd4, 32'd64, 1'b0);
    rd(4'd4, 32'd64);
    idle(2);
    check("rdata_hold", rdata, 32'd64);
    rd(4'd6, 32'd1);
    // tx_start / tx_done ignored outside READY / LOCKED
    step(1'b0, 1'b0, 4'd0, 32'd0, 2'b10, 2'b10, 1'b0, 32'd0);
    rd(4'd6, 32'd1);
    // ch1 READY behaviours: size update stays, burst reprogram drops back
    wr(4'd5, 32'd2, 1'b0);
    wr(4'd5, 32'd1, 1'b0);
    rd(4'd5, 32'd1);
    rd(4'd6, 32'd6);
    wr(4'd4, 32'd1, 1'b0);
    idle(1);
    rd(4'd6, 32'd1);
    // read and write of the same register: pre-write value returned
    step(1'b1, 1'b1, 4'd4, 32'd32, 2'b00, 2'b00, 1'b0, 32'd1);
    rd(4'd4, 32'd32);

    // ch0 LOCKED: writes rejected, tx_done returns to EMPTY with values kept
    step(1'b0, 1'b0, 4'd0, 32'd0, 2'b01, 2'b00, 1'b0, 32'd0);
    idle(1);
    check("locked_ready", {31'd0, cfg_ready[0]}, 32'd0);
    rd(4'd2, 32'd3);
    wr(4'd0, 32'd8, 1'b1);
    rd(4'd0, 32'd16);
    step(1'b0, 1'b0, 4'd0, 32'd0, 2'b00, 2'b01, 1'b0, 32'd0);
    rd(4'd2, 32'd0);
    check("kept_burst", {25'd0, cfg_burst[6:0]}, 32'd16);
    check("kept_size", {29'd0, cfg_size[2:0]}, 32'd4);

    // tx_start beats a coincident write to the same READY channel
    wr(4'd0, 32'd16, 1'b0);
    wr(4'd1, 32'd4, 1'b0);
    step(1'b1, 1'b0, 4'd1, 32'd2, 2'b01, 2'b00, 1'b1, 32'd0);
    idle(1);
    check("race_size", {29'd0, cfg_size[2:0]}, 32'd4);
    rd(4'd2, 32'd3);
    step(1'b0, 1'b0, 4'd0, 32'd0, 2'b00, 2'b01, 1'b0, 32'd0);

    // invalid channel and read-only / reserved offsets
    wr(4'd12, 32'd16, 1'b1);
    wr(4'd2, 32'd16, 1'b1);
    wr(4'd3, 32'd16, 1'b1);
    rd(4'd12, 32'd0);
    rd(4'd2, 32'd0);
    rd(4'd3, 32'd0);

    // reset mid-operation with ch0 in BURST_OK and a wr_err pulse in flight
    rd(4'd4, 32'd32);
    wr(4'd0, 32'd16, 1'b0);
    wr(4'd1, 32'd5, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {30'd0, cfg_ready}, 32'd0);
    check("mid_rst_burst", {18'd0, cfg_burst}, 32'd0);
    check("mid_rst_size", {26'd0, cfg_size}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_wr_err", {31'd0, wr_err}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    rd(4'd2, 32'd0);
    rd(4'd0, 32'd0);
    idle(3);

    check("rd_queue_empty", rd_q.size(), 32'd0);
    check("err_queue_empty", err_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
